// File: rtl/data_memory_responder_if.sv
// CPU data-memory port bundle: request strobes and payload from the CPU,
// read data and stall back from the memory responder.
interface data_memory_responder_if;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  modport master (
    output READ,
    output WRITE,
    output ADDRESS,
    output WRITEDATA,
    input  READDATA,
    input  BUSYWAIT
  );

  modport slave (
    input  READ,
    input  WRITE,
    input  ADDRESS,
    input  WRITEDATA,
    output READDATA,
    output BUSYWAIT
  );
endinterface

// File: rtl/data_memory_responder.sv
// Slow data memory: latches one READ/WRITE request, stalls the CPU via BUSYWAIT for
// LATENCY cycles, performs the access, then spends one DONE cycle ignoring strobes.
module data_memory_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 5
) (
  input logic                    CLK,
  input logic                    RESET,
  data_memory_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           is_write_q, is_write_d;
  logic [7:0]     rdata_q, rdata_d;
  logic [7:0]     mem_q [DEPTH];
  logic           mem_we;
  logic           req;
  logic [AW-1:0]  req_idx;

  assign req     = bus.READ | bus.WRITE;
  // Addresses beyond the array wrap back into it.
  assign req_idx = AW'(32'(bus.ADDRESS) % DEPTH);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d    = StBusy;
          cnt_d      = 4'(LATENCY - 1);
          addr_d     = req_idx;
          wdata_d    = bus.WRITEDATA;
          // READ and WRITE together resolve to a write.
          is_write_d = bus.WRITE;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          if (is_write_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      is_write_q <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Idle term is combinational so the stall appears in the cycle the strobe rises.
  assign bus.BUSYWAIT = ((state_q == StIdle) && req) || (state_q == StBusy);
  assign bus.READDATA = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with a queue-based scoreboard checking READDATA
// at every access completion (LATENCY=5 and LATENCY=1 instances).
module tb_data_memory_responder;

  logic clk;
  logic rst_n;

  data_memory_responder_if bus0 ();
  data_memory_responder_if bus1 ();

  data_memory_responder #(.DEPTH(256), .LATENCY(5)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus0)
  );

  data_memory_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard monitors: a BUSYWAIT fall outside reset marks a completed access.
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  always begin
    logic [7:0] e;
    @(negedge clk);
    #2;
    if (rst_n && prev0 && !bus0.BUSYWAIT) begin
      if (exp_q0.size() == 0) fail_now("unexpected_done0");
      else begin
        e = exp_q0.pop_front();
        check("rdata0", {24'h0, bus0.READDATA}, {24'h0, e});
      end
    end
    prev0 = bus0.BUSYWAIT;
  end

  always begin
    logic [7:0] e;
    @(negedge clk);
    #2;
    if (rst_n && prev1 && !bus1.BUSYWAIT) begin
      if (exp_q1.size() == 0) fail_now("unexpected_done1");
      else begin
        e = exp_q1.pop_front();
        check("rdata1", {24'h0, bus1.READDATA}, {24'h0, e});
      end
    end
    prev1 = bus1.BUSYWAIT;
  end

  // One access on the LATENCY=5 port; ADDRESS/WRITEDATA are scrambled after capture.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input string name);
    int stall;
    @(negedge clk);
    bus0.READ = rd;
    bus0.WRITE = wr;
    bus0.ADDRESS = a;
    bus0.WRITEDATA = d;
    exp_q0.push_back(exp_rd);
    #1;
    check({name, "_bw_comb"}, {31'h0, bus0.BUSYWAIT}, 32'd1);
    @(posedge clk);
    #1;
    bus0.READ = 1'b0;
    bus0.WRITE = 1'b0;
    bus0.ADDRESS = a + 8'd1;
    bus0.WRITEDATA = 8'hFF;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!bus0.BUSYWAIT) break;
      stall++;
      if (stall > 40) begin
        fail_now({name, "_timeout"});
        break;
      end
    end
    check({name, "_stall"}, stall, 32'd5);
  endtask

  // READ held high continuously; BUSYWAIT pattern repeats every L+2 cycles.
  task automatic gap_test(input int sel, input int lat, input logic [7:0] a,
                          input logic [7:0] val);
    logic bw;
    @(negedge clk);
    if (sel == 0) begin
      exp_q0.push_back(val);
      exp_q0.push_back(val);
      bus0.ADDRESS = a;
      bus0.READ = 1'b1;
    end else begin
      exp_q1.push_back(val);
      exp_q1.push_back(val);
      bus1.ADDRESS = a;
      bus1.READ = 1'b1;
    end
    for (int k = 0; k < 2 * (lat + 2); k++) begin
      if (k > 0) @(negedge clk);
      #1;
      bw = (sel == 0) ? bus0.BUSYWAIT : bus1.BUSYWAIT;
      check($sformatf("gap%0d_bw_%0d", sel, k), {31'h0, bw},
            {31'h0, (k % (lat + 2)) != (lat + 1)});
    end
    bus0.READ = 1'b0;
    bus1.READ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus0.READ = 1'b0; bus0.WRITE = 1'b0; bus0.ADDRESS = 8'h00; bus0.WRITEDATA = 8'h00;
    bus1.READ = 1'b0; bus1.WRITE = 1'b0; bus1.ADDRESS = 8'h00; bus1.WRITEDATA = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset_rdata", {24'h0, bus0.READDATA}, 32'h00);
    check("reset_bw", {31'h0, bus0.BUSYWAIT}, 32'd0);
    check("reset_rdata1", {24'h0, bus1.READDATA}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b1, 1'b0, 8'h10, 8'h00, 8'h00, "rd10");
    access(1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00, "wr3c");
    access(1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, "rd3c");
    access(1'b0, 1'b1, 8'h20, 8'h11, 8'hA5, "wr20");
    access(1'b1, 1'b0, 8'h20, 8'h00, 8'h11, "rd20");
    access(1'b1, 1'b0, 8'h21, 8'h00, 8'h00, "rd21");
    access(1'b0, 1'b1, 8'h06, 8'h77, 8'h00, "wr06");
    access(1'b1, 1'b0, 8'h06, 8'h00, 8'h77, "rd06");
    access(1'b1, 1'b1, 8'h05, 8'h9C, 8'h77, "rdwr05");
    access(1'b1, 1'b0, 8'h05, 8'h00, 8'h9C, "rd05");

    // Write aborted by reset on the third cycle.
    @(negedge clk);
    bus0.WRITE = 1'b1;
    bus0.ADDRESS = 8'h40;
    bus0.WRITEDATA = 8'hEE;
    @(posedge clk);
    #1;
    bus0.WRITE = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_bw", {31'h0, bus0.BUSYWAIT}, 32'd0);
    check("midrst_rdata", {24'h0, bus0.READDATA}, 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    access(1'b1, 1'b0, 8'h40, 8'h00, 8'h00, "rd40");
    access(1'b1, 1'b0, 8'h05, 8'h00, 8'h00, "rd05_clr");
    access(1'b0, 1'b1, 8'h41, 8'h5A, 8'h00, "wr41");
    access(1'b1, 1'b0, 8'h41, 8'h00, 8'h5A, "rd41");

    gap_test(0, 5, 8'h41, 8'h5A);
    gap_test(1, 1, 8'h33, 8'h00);

    repeat (4) @(negedge clk);
    check("q0_empty", exp_q0.size(), 32'd0);
    check("q1_empty", exp_q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
